instr_fetch_unit: RTL and testbench

Instruction fetch unit for the multi-cycle ARM core. It owns the program counter and the instruction register and runs the memory read handshake. It answers the control FSM's fetch requests (`write_ir`/`write_pc`, `pc_s`) with a fetched instruction and a one-cycle `ir_valid` pulse. It sits between the control FSM and the instruction memory port.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction memory read port between the fetch unit and instruction memory.
//   mem_rd    : read request, held until mem_ready
//   mem_addr  : word-aligned read address, stable while mem_rd is high
//   mem_rdata : read data, valid in the cycle mem_ready is high
//   mem_ready : memory acknowledge, one per request
// Modports: master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the program counter and instruction register of the multi-cycle ARM
// core and runs the instruction memory read handshake for the control FSM.
//
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   fetch_req  : level request for the next instruction (write_ir)
//   pc_we      : PC write strobe (write_pc)
//   pc_sel     : 00 sequential (no-op), 01 load pc_rm, 10 load pc_branch,
//                11 ignored
//   pc_rm      : register-sourced target (BX)
//   pc_branch  : ALU-computed branch target
//   mem        : instruction memory read port (master side)
//   ir         : instruction register
//   ir_valid   : one-cycle pulse, ir freshly updated
//   pc         : current PC
//   fetch_err  : one-cycle pulse after a fetch times out
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetch_req,
   input  logic                       pc_we,
   input  logic [1:0]                 pc_sel,
   input  logic [31:0]                pc_rm,
   input  logic [31:0]                pc_branch,
   instr_fetch_unit_if.master         mem,
   output logic [31:0]                ir,
   output logic                       ir_valid,
   output logic [31:0]                pc,
   output logic                       fetch_err
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   // Value of the wait counter on the last REQ cycle allowed before timeout
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_reg,     state_next;
   logic [31:0] pc_reg,        pc_next;
   logic [31:0] ir_reg,        ir_next;
   logic        ir_valid_reg,  ir_valid_next;
   logic        fetch_err_reg, fetch_err_next;
   logic        mem_rd_reg,    mem_rd_next;
   logic [31:0] mem_addr_reg,  mem_addr_next;
   logic [7:0]  wait_cnt_reg,  wait_cnt_next;
   logic        discard_reg,   discard_next;

   logic        redirect;
   logic [31:0] redirect_pc;

   // Only the two explicit load selects move the PC; the sequential select
   // is a no-op because the +4 is applied at fetch completion.
   assign redirect    = pc_we && ((pc_sel == 2'b01) || (pc_sel == 2'b10));
   assign redirect_pc = ((pc_sel == 2'b01) ? pc_rm : pc_branch) & 32'hFFFF_FFFC;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         ir_reg        <= 32'h0;
         ir_valid_reg  <= 1'b0;
         fetch_err_reg <= 1'b0;
         mem_rd_reg    <= 1'b0;
         mem_addr_reg  <= RESET_PC;
         wait_cnt_reg  <= 8'h0;
         discard_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         ir_reg        <= ir_next;
         ir_valid_reg  <= ir_valid_next;
         fetch_err_reg <= fetch_err_next;
         mem_rd_reg    <= mem_rd_next;
         mem_addr_reg  <= mem_addr_next;
         wait_cnt_reg  <= wait_cnt_next;
         discard_reg   <= discard_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = redirect ? redirect_pc : pc_reg;
      ir_next        = ir_reg;
      ir_valid_next  = 1'b0;
      fetch_err_next = 1'b0;
      mem_rd_next    = mem_rd_reg;
      mem_addr_next  = mem_addr_reg;
      wait_cnt_next  = wait_cnt_reg;
      discard_next   = discard_reg;

      case (state_reg)
         IDLE: begin
            if (fetch_req) begin
               // A load arriving in the same cycle is honoured by fetching
               // from the new PC, so pc and mem_addr never disagree.
               mem_addr_next = pc_next;
               mem_rd_next   = 1'b1;
               wait_cnt_next = 8'h0;
               discard_next  = 1'b0;
               state_next    = REQ;
            end
         end

         REQ: begin
            if (mem.mem_ready) begin
               mem_rd_next = 1'b0;
               if (discard_reg || redirect) begin
                  // Stale data for a superseded PC: drop it silently
                  discard_next = 1'b0;
                  state_next   = IDLE;
               end else begin
                  ir_next       = mem.mem_rdata;
                  pc_next       = pc_reg + 32'd4;
                  ir_valid_next = 1'b1;
                  state_next    = DONE;
               end
            end else if (wait_cnt_reg == WAIT_LAST) begin
               mem_rd_next    = 1'b0;
               fetch_err_next = 1'b1;
               discard_next   = 1'b0;
               state_next     = IDLE;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
               if (redirect) begin
                  discard_next = 1'b1;
               end
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem.mem_rd   = mem_rd_reg;
   assign mem.mem_addr = mem_addr_reg;
   assign ir           = ir_reg;
   assign ir_valid     = ir_valid_reg;
   assign pc           = pc_reg;
   assign fetch_err    = fetch_err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Randomised bench for instr_fetch_unit. The driver plays both the control
// FSM and the instruction memory; for every fetch it predicts the outcome
// from a transaction-level model (current PC, last instruction) and pushes
// it to a queue. A separate monitor pops an entry whenever the unit pulses
// ir_valid or fetch_err and compares.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          TMO    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic        pc_we = 1'b0;
   logic [1:0]  pc_sel = 2'b00;
   logic [31:0] pc_rm = 32'h0;
   logic [31:0] pc_branch = 32'h0;
   logic [31:0] ir, pc;
   logic        ir_valid, fetch_err;

   instr_fetch_unit_if mem_if ();

   instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .fetch_req (fetch_req),
      .pc_we     (pc_we),
      .pc_sel    (pc_sel),
      .pc_rm     (pc_rm),
      .pc_branch (pc_branch),
      .mem       (mem_if.master),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .pc        (pc),
      .fetch_err (fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [31:0] ir;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;

   // Reference model state
   logic [31:0] model_pc = RST_PC;
   logic [31:0] model_ir = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: one line per observed output transaction
   always @(negedge clk) begin
      if (!rst && (ir_valid || fetch_err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {30'h0, ir_valid, fetch_err}, 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("kind_err", {31'h0, fetch_err}, {31'h0, e.is_err});
            check("kind_valid", {31'h0, ir_valid}, {31'h0, !e.is_err});
            check("ir", ir, e.ir);
            check("pc", pc, e.pc);
            $display("%0t %s ir=%h pc=%h", $time, e.is_err ? "fetch_err" : "ir_valid", ir, pc);
         end
      end
   end

   task automatic drive_noop(input bit hold);
      pc_rm     = $urandom;
      pc_branch = $urandom;
      if (hold) begin
         pc_we  = 1'b1;
         pc_sel = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
      end else begin
         pc_we  = 1'b0;
         pc_sel = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic do_load(input logic [1:0] sel, input logic [31:0] val);
      @(negedge clk);
      fetch_req = 1'b0;
      pc_we     = 1'b1;
      pc_sel    = sel;
      pc_rm     = (sel == 2'b01) ? val : $urandom;
      pc_branch = (sel == 2'b10) ? val : $urandom;
      model_pc  = val & 32'hFFFF_FFFC;
      @(negedge clk);
      pc_we = 1'b0;
      check("pc_load", pc, model_pc);
      $display("%0t load sel=%b val=%h pc=%h", $time, sel, val, pc);
   endtask

   // w wait states; redir >= 0 injects a load in REQ cycle redir (0..w)
   task automatic do_fetch(input int w, input logic [31:0] data, input int redir,
                           input logic [1:0] rsel, input logic [31:0] rval, input bit hold);
      logic [31:0] exp_addr;
      @(negedge clk);
      fetch_req = 1'b1;
      drive_noop(hold);
      exp_addr = model_pc;
      for (int i = 0; i <= w; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("mem_addr", mem_if.mem_addr, exp_addr);
            fetch_req = 1'b0;
         end
         check("mem_rd_hold", {31'h0, mem_if.mem_rd}, 32'h1);
         mem_if.mem_ready = (i == w);
         mem_if.mem_rdata = (i == w) ? data : $urandom;
         if (i == redir) begin
            pc_we     = 1'b1;
            pc_sel    = rsel;
            pc_rm     = (rsel == 2'b01) ? rval : $urandom;
            pc_branch = (rsel == 2'b10) ? rval : $urandom;
         end else begin
            drive_noop(hold);
         end
      end
      if (redir >= 0) begin
         model_pc = rval & 32'hFFFF_FFFC;
      end else begin
         exp_q.push_back('{is_err: 1'b0, ir: data, pc: model_pc + 32'd4});
         model_pc = model_pc + 32'd4;
         model_ir = data;
      end
      @(negedge clk);
      mem_if.mem_ready = 1'b0;
      pc_we            = 1'b0;
      check("ir_valid_time", {31'h0, ir_valid}, {31'h0, (redir < 0)});
      check("mem_rd_end", {31'h0, mem_if.mem_rd}, 32'h0);
      check("pc_after", pc, model_pc);
      $display("%0t fetch addr=%h w=%0d redir=%0d data=%h pc=%h", $time, exp_addr, w, redir, data, pc);
   endtask

   task automatic do_timeout();
      logic [31:0] exp_addr;
      @(negedge clk);
      fetch_req = 1'b1;
      drive_noop(1'b0);
      exp_addr = model_pc;
      exp_q.push_back('{is_err: 1'b1, ir: model_ir, pc: model_pc});
      @(negedge clk);
      fetch_req        = 1'b0;
      mem_if.mem_ready = 1'b0;
      check("mem_addr", mem_if.mem_addr, exp_addr);
      for (int i = 1; i < TMO; i++) begin
         check("tmo_mem_rd", {31'h0, mem_if.mem_rd}, 32'h1);
         check("err_early", {31'h0, fetch_err}, 32'h0);
         @(negedge clk);
      end
      check("tmo_mem_rd_last", {31'h0, mem_if.mem_rd}, 32'h1);
      @(negedge clk);
      check("err_time", {31'h0, fetch_err}, 32'h1);
      check("tmo_mem_rd_drop", {31'h0, mem_if.mem_rd}, 32'h0);
      $display("%0t timeout addr=%h pc=%h", $time, exp_addr, pc);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pc"}, pc, RST_PC);
      check({tag, "_ir"}, ir, 32'h0);
      check({tag, "_ir_valid"}, {31'h0, ir_valid}, 32'h0);
      check({tag, "_fetch_err"}, {31'h0, fetch_err}, 32'h0);
      check({tag, "_mem_rd"}, {31'h0, mem_if.mem_rd}, 32'h0);
      check({tag, "_mem_addr"}, mem_if.mem_addr, RST_PC);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, kind, redir;
      mem_if.mem_ready = 1'b0;
      mem_if.mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Directed scenarios
      do_fetch(0, 32'hE081_0002, -1, 2'b00, 32'h0, 1'b1);
      do_fetch(3, $urandom, -1, 2'b00, 32'h0, 1'b1);
      do_fetch(2, $urandom, 1, 2'b10, 32'h0000_2003, 1'b0);
      do_fetch(0, $urandom, -1, 2'b00, 32'h0, 1'b0);
      do_load(2'b01, 32'h0000_3001);
      do_fetch(1, $urandom, -1, 2'b00, 32'h0, 1'b0);
      do_fetch(1, $urandom, 1, 2'b01, 32'h0000_4442, 1'b0);
      do_timeout();
      do_load(2'b10, 32'hFFFF_FFFF);
      do_fetch(0, $urandom, -1, 2'b00, 32'h0, 1'b0);

      // Random mix
      for (int t = 0; t < 80; t++) begin
         kind = $urandom_range(0, 9);
         w    = $urandom_range(0, TMO - 1);
         if (kind <= 1) begin
            do_load(2'($urandom_range(1, 2)), $urandom);
         end else if (kind == 2) begin
            do_timeout();
         end else begin
            redir = (kind <= 4) ? $urandom_range(0, w) : -1;
            do_fetch(w, $urandom, redir, 2'($urandom_range(1, 2)), $urandom,
                     1'($urandom_range(0, 1)));
         end
      end

      // Reset in the middle of a request
      @(negedge clk);
      fetch_req = 1'b1;
      @(negedge clk);
      check("pre_rst_mem_rd", {31'h0, mem_if.mem_rd}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      fetch_req = 1'b0;
      model_pc  = RST_PC;
      model_ir  = 32'h0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      do_fetch(2, $urandom, -1, 2'b00, 32'h0, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_drain", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
